if_ctrl: RTL
============

IF_CTRL -- requirements
Module: if_ctrl

Interface
REQ-001 The block SHALL have a parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have a parameter PC_INCR, default 4, giving the sequential PC step in bytes.
REQ-003 clk_in  input  1  the single clock; all state changes on its rising edge.
REQ-004 n_rst_in  input  1  reset; asynchronous, active-low.
REQ-005 pc_branch_in  input  32  redirect target; sampled only when ctrl_pc_src_in=1.
REQ-006 ctrl_pc_src_in  input  1  redirect request from the branch resolver; 1 = take pc_branch_in.
REQ-007 stall_in  input  1  hazard stall; 1 = IF/ID register must hold.
REQ-008 mem_req_out  output  1  instruction-memory read request.
REQ-009 mem_addr_out  output  32  instruction-memory read address.
REQ-010 mem_ack_in  input  1  memory done; mem_rdata_in valid in the same cycle.
REQ-011 mem_rdata_in  input  32  fetched instruction word.
REQ-012 IFID_pc_out  output  32  PC of the instruction held in IF/ID.
REQ-013 IFID_ir_out  output  32  instruction held in IF/ID.
REQ-014 IFID_valid_out  output  1  1 = IF/ID holds a live instruction; 0 = bubble.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, SQUASH, HOLD; mem_req_out=1 exactly in FETCH and SQUASH.
REQ-016 mem_addr_out SHALL equal the PC register and SHALL stay constant while mem_req_out=1 and mem_ack_in=0.
REQ-017 IDLE SHALL go to FETCH on the first clock edge after reset release.
REQ-018 FETCH, ack, no redirect, stall_in=0: IF/ID <= {PC, rdata, valid=1}, PC <= PC+PC_INCR, stay FETCH.
REQ-019 FETCH, ack, no redirect, stall_in=1: IF/ID unchanged; word and PC go to a one-entry hold buffer; state goes to HOLD.
REQ-020 HOLD, stall_in=0, no redirect: IF/ID <= buffer with valid=1, PC <= PC+PC_INCR, state goes to FETCH.
REQ-021 FETCH, redirect, mem_ack_in=1: returned word discarded, PC <= pc_branch_in, IFID_valid_out <= 0, stay FETCH.
REQ-022 FETCH, redirect, mem_ack_in=0: target saved, IFID_valid_out <= 0, state goes to SQUASH; request stays at the old address.
REQ-023 SQUASH, mem_ack_in=1: word discarded, PC <= saved target, state goes to FETCH.
REQ-024 A redirect arriving during SQUASH SHALL overwrite the saved target (latest wins).
REQ-025 HOLD, redirect: buffer dropped, PC <= pc_branch_in, IFID_valid_out <= 0, state goes to FETCH.
REQ-026 Redirect SHALL take priority over stall_in: IFID_valid_out clears even when stall_in=1.
REQ-027 With no redirect, IF/ID SHALL hold all fields while stall_in=1.
REQ-028 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
REQ-029 Sequential throughput SHALL be one instruction per cycle when mem_ack_in returns in the same cycle as the request.

Reset
REQ-030 While n_rst_in=0: state=IDLE, PC=RESET_PC, mem_req_out=0, IFID_pc_out=0, IFID_ir_out=0, IFID_valid_out=0, hold buffer empty, saved target=0.
REQ-031 Reset asserted mid-request SHALL abandon the request immediately; a late mem_ack_in SHALL be ignored until FETCH is re-entered.

Structure
REQ-032 State encoding, RESET_PC default and PC_INCR SHALL live in the shared package if_pkg.
REQ-033 The design SHALL be a single module with no sub-module; the hold buffer and PC are local registers.

Verification
REQ-034 Reset, ack tied high, no stall -> IFID_pc_out steps 0, 4, 8, 12 on consecutive cycles with IFID_valid_out=1.
REQ-035 Ack delayed 3 cycles -> mem_addr_out held at 32'h8 for 3 cycles; IF/ID updates once, to pc=8.
REQ-036 stall_in=1 for 2 cycles during an ack at pc=0x10 -> IF/ID frozen; pc=0x10 appears in IF/ID the cycle after release; no fetch is lost or duplicated.
REQ-037 Redirect to 32'h100 while an ack is pending at 0x20 -> word 0x20 is discarded; the next request is to 0x100; IFID_valid_out is 0 for that gap.
REQ-038 Redirect coinciding with an ack, and redirect during HOLD -> the next address is pc_branch_in with one bubble; PC 32'hFFFF_FFFC wraps to 0.
REQ-039 n_rst_in pulsed low mid-request -> all outputs return to their reset values asynchronously; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// if_pkg: shared FSM encoding and fetch-address defaults for the instruction-fetch controller.
package if_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, SQUASH, HOLD} if_state_e;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] IF_PC_INCR  = 32'd4;
endpackage

// File: rtl/if_ctrl.sv
// if_ctrl: instruction-fetch stage; drives the I-mem request and loads the IF/ID register,
// handling stalls via a one-entry hold buffer and redirects via squash of in-flight fetches.
module if_ctrl
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC,
  parameter logic [31:0] PC_INCR  = IF_PC_INCR
) (
  input  logic        clk_in,
  input  logic        n_rst_in,
  input  logic [31:0] pc_branch_in,
  input  logic        ctrl_pc_src_in,
  input  logic        stall_in,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_ack_in,
  input  logic [31:0] mem_rdata_in,
  output logic [31:0] IFID_pc_out,
  output logic [31:0] IFID_ir_out,
  output logic        IFID_valid_out
);
  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d, tgt_q, tgt_d;
  logic [31:0] hold_pc_q, hold_pc_d, hold_ir_q, hold_ir_d;
  logic [31:0] ifid_pc_q, ifid_pc_d, ifid_ir_q, ifid_ir_d;
  logic        ifid_v_q, ifid_v_d;

  always_ff @(posedge clk_in or negedge n_rst_in)
    if (!n_rst_in) state_q <= IDLE;
    else           state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   state_d = (ctrl_pc_src_in && !mem_ack_in) ? SQUASH :
                         (!ctrl_pc_src_in && mem_ack_in && stall_in) ? HOLD : FETCH;
      SQUASH:  state_d = mem_ack_in ? FETCH : SQUASH;
      HOLD:    state_d = (ctrl_pc_src_in || !stall_in) ? FETCH : HOLD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_out    = (state_q == FETCH) || (state_q == SQUASH);
    mem_addr_out   = pc_q;
    IFID_pc_out    = ifid_pc_q;
    IFID_ir_out    = ifid_ir_q;
    IFID_valid_out = ifid_v_q;
  end

  always_ff @(posedge clk_in or negedge n_rst_in)
    if (!n_rst_in) begin
      pc_q      <= RESET_PC;
      tgt_q     <= '0;
      hold_pc_q <= '0;
      hold_ir_q <= '0;
      ifid_pc_q <= '0;
      ifid_ir_q <= '0;
      ifid_v_q  <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      hold_pc_q <= hold_pc_d;
      hold_ir_q <= hold_ir_d;
      ifid_pc_q <= ifid_pc_d;
      ifid_ir_q <= ifid_ir_d;
      ifid_v_q  <= ifid_v_d;
    end

  // Redirect always wins over stall; a redirect without ack parks the target until the old request drains.
  always_comb begin
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    hold_pc_d = hold_pc_q;
    hold_ir_d = hold_ir_q;
    ifid_pc_d = ifid_pc_q;
    ifid_ir_d = ifid_ir_q;
    ifid_v_d  = ifid_v_q;
    case (state_q)
      FETCH:
        if (ctrl_pc_src_in) begin
          ifid_v_d = 1'b0;
          if (mem_ack_in) pc_d = pc_branch_in;
          else            tgt_d = pc_branch_in;
        end else if (mem_ack_in && stall_in) begin
          hold_pc_d = pc_q;
          hold_ir_d = mem_rdata_in;
        end else if (mem_ack_in) begin
          ifid_pc_d = pc_q;
          ifid_ir_d = mem_rdata_in;
          ifid_v_d  = 1'b1;
          pc_d      = pc_q + PC_INCR;
        end
      SQUASH: begin
        if (ctrl_pc_src_in) tgt_d = pc_branch_in;
        if (mem_ack_in)     pc_d  = ctrl_pc_src_in ? pc_branch_in : tgt_q;
      end
      HOLD:
        if (ctrl_pc_src_in) begin
          ifid_v_d = 1'b0;
          pc_d     = pc_branch_in;
        end else if (!stall_in) begin
          ifid_pc_d = hold_pc_q;
          ifid_ir_d = hold_ir_q;
          ifid_v_d  = 1'b1;
          pc_d      = pc_q + PC_INCR;
        end
      default: ;
    endcase
  end
endmodule
